// File: rtl/act_requant_pipe_if.sv
// act_requant_pipe_if: input/output beat handshake bundle for act_requant_pipe
interface act_requant_pipe_if #(
   parameter int LANES = 4,
   parameter int IN_W  = 24,
   parameter int OUT_W = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*IN_W-1:0]  in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*OUT_W-1:0] out_data;
   logic                   out_last;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/act_requant_pipe.sv
// act_requant_pipe: 3-stage bias/dequant, activation, requant/saturate stream with tile FSM
// Optional saturation counter enabled by defining ACT_SAT_CNT_EN.
module act_requant_pipe #(
   parameter int LANES    = 4,
   parameter int IN_W     = 24,
   parameter int OUT_W    = 8,
   parameter int DQ_SHIFT = 13,
   parameter int RQ_SHIFT = 8,
   parameter int LEN_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          cfg_mode,
   input  logic [IN_W-1:0]     cfg_bias,
   input  logic [7:0]          cfg_dq_scale,
   input  logic [7:0]          cfg_rq_scale,
   input  logic [LEN_W-1:0]    cfg_len,
   act_requant_pipe_if.slave   strm,
   output logic                busy,
   output logic                done,
   output logic [15:0]         sat_cnt
);
   localparam int D_W = IN_W + 10;
   localparam int R_W = D_W + 9;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   localparam logic signed [D_W-1:0] C3 = D_W'(768);
   localparam logic signed [D_W-1:0] C6 = D_W'(1536);
   localparam logic signed [R_W-1:0] RND = R_W'(2 ** (RQ_SHIFT - 1));
   localparam logic signed [R_W-1:0] OMAX = R_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [R_W-1:0] OMIN = R_W'(-(2 ** (OUT_W - 1)));

   logic [1:0]             state;
   logic [1:0]             mode;
   logic signed [IN_W-1:0] bias;
   logic [7:0]             dq, rq;
   logic [LEN_W-1:0]       len, in_cnt, out_cnt;
   logic                   v1, v2, v3, ld1, ld2, ld3, in_fire, out_fire;
   logic [LANES*OUT_W-1:0] r_c;
`ifdef ACT_SAT_CNT_EN
   logic [LANES-1:0]       sat_c, s3_sat;
   logic [16:0]            sat_sum;
`endif

   // a stage loads when it is empty or its contents move on this cycle
   assign ld3 = !v3 || strm.out_ready;
   assign ld2 = !v2 || ld3;
   assign ld1 = !v1 || ld2;
   assign strm.in_ready = state == RUN && ld1;
   assign in_fire = strm.in_valid && strm.in_ready;
   assign out_fire = v3 && strm.out_ready;
   assign strm.out_valid = v3;
   assign strm.out_last = v3 && out_cnt == len - 1'b1;
   assign busy = state != IDLE;
   assign done = state == DONE;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [IN_W:0]  xb;
      logic signed [D_W-1:0] d_c, s1_d, y_c, s2_y;
      logic signed [10:0]    dm;
      logic signed [31:0]    dw, hs;
      logic signed [R_W-1:0] rs;
      assign xb = $signed(strm.in_data[i*IN_W +: IN_W]) + bias;
      assign d_c = (xb * $signed({1'b0, dq})) >>> DQ_SHIFT;
      // h_swish middle segment only sees |d| < 768, so 11 bits carry it
      assign dm = s1_d[10:0];
      assign dw = 32'(dm);
      assign hs = (dw * (dw + 32'sd768) * 32'sd43) >>> 16;
      assign y_c = mode == 2'd0 ? s1_d
                 : mode == 2'd3 ? (s1_d <= -C3 ? '0 : s1_d >= C3 ? s1_d : D_W'(hs))
                 : s1_d[D_W-1] ? '0
                 : (mode == 2'd2 && s1_d > C6) ? C6 : s1_d;
      assign rs = (s2_y * $signed({1'b0, rq}) + RND) >>> RQ_SHIFT;
      assign r_c[i*OUT_W +: OUT_W] = rs > OMAX ? OUT_W'(OMAX) : rs < OMIN ? OUT_W'(OMIN) : rs[OUT_W-1:0];
`ifdef ACT_SAT_CNT_EN
      assign sat_c[i] = rs > OMAX || rs < OMIN;
`endif
      always_ff @(posedge clk) begin
         if (ld1 && in_fire) s1_d <= d_c;
         if (ld2 && v1) s2_y <= y_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         {v1, v2, v3} <= '0;
         in_cnt <= '0;
         out_cnt <= '0;
         strm.out_data <= '0;
         mode <= '0;
         bias <= '0;
         dq <= '0;
         rq <= '0;
         len <= '0;
      end else begin
         if (ld1) v1 <= in_fire;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
         if (ld3 && v2) strm.out_data <= r_c;
         if (in_fire) in_cnt <= in_cnt + 1'b1;
         if (out_fire) out_cnt <= out_cnt + 1'b1;
         case (state)
            IDLE: if (start) begin
               mode <= cfg_mode;
               bias <= cfg_bias;
               dq <= cfg_dq_scale;
               rq <= cfg_rq_scale;
               len <= cfg_len;
               in_cnt <= '0;
               out_cnt <= '0;
               state <= cfg_len == '0 ? DONE : RUN;
            end
            RUN: if (in_fire && in_cnt + 1'b1 == len) state <= DRAIN;
            DRAIN: if (out_fire && strm.out_last) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACT_SAT_CNT_EN
   always_comb begin
      sat_sum = {1'b0, sat_cnt};
      for (int i = 0; i < LANES; i++) sat_sum = sat_sum + 17'(s3_sat[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt <= '0;
         s3_sat <= '0;
      end else begin
         if (ld3 && v2) s3_sat <= sat_c;
         if (state == IDLE && start) sat_cnt <= '0;
         else if (out_fire) sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end
`else
   assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_act_requant_pipe.sv
// tb_act_requant_pipe: scoreboard bench for act_requant_pipe (directed, backpressure, random, reset)
module tb_act_requant_pipe;
   localparam int LANES = 4, IN_W = 24, OUT_W = 8, LEN_W = 16;
`ifdef ACT_SAT_CNT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif
   typedef struct {
      logic [LANES*OUT_W-1:0] data;
      logic                   last;
      int                     nsat;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0] cfg_mode = '0;
   logic [IN_W-1:0] cfg_bias = '0;
   logic [7:0] cfg_dq_scale = '0, cfg_rq_scale = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic busy, done;
   logic [15:0] sat_cnt;
   exp_t exp_q[$];
   logic [OUT_W-1:0] out_log[$];
   int n_cmp = 0, n_err = 0, cyc = 0, n_in = 0, n_out = 0;
   int done_cnt = 0, done_cyc = 0, last_cyc = 0, start_cyc = 0, exp_sat = 0;
   int c_mode, c_bias, c_dq, c_rq, c_len;
   bit saw_stall = 0, rand_rdy = 0;

   act_requant_pipe_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   act_requant_pipe dut (
      .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_bias(cfg_bias),
      .cfg_dq_scale(cfg_dq_scale), .cfg_rq_scale(cfg_rq_scale), .cfg_len(cfg_len),
      .strm(bus.slave), .busy(busy), .done(done), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rand_rdy) #1 bus.out_ready = 1'($urandom_range(0, 1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [OUT_W-1:0] model(input longint x, output bit sat);
      longint d, y, r;
      d = ((x + c_bias) * c_dq) >>> 13;
      case (c_mode)
         0: y = d;
         1: y = d < 0 ? 0 : d;
         2: y = d < 0 ? 0 : (d > 1536 ? 1536 : d);
         default: y = d <= -768 ? 0 : (d >= 768 ? d : (d * (d + 768) * 43) >>> 16);
      endcase
      r = (y * c_rq + 128) >>> 8;
      sat = r > 127 || r < -128;
      r = r > 127 ? 127 : (r < -128 ? -128 : r);
      return OUT_W'(r);
   endfunction

   function automatic logic [LANES*IN_W-1:0] pk(input int a, input int b, input int c, input int d);
      return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
            exp_sat = exp_sat + e.nsat > 65535 ? 65535 : exp_sat + e.nsat;
            if (bus.out_last) last_cyc = cyc;
         end
         out_log.push_back(bus.out_data[OUT_W-1:0]);
         n_out++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         chk("busy_at_done", busy, 1);
      end
      if (bus.in_valid && !bus.in_ready && busy) saw_stall = 1;
   end

   task automatic start_tile(input int mode, input int bias, input int dq, input int rq, input int len);
      c_mode = mode; c_bias = bias; c_dq = dq; c_rq = rq; c_len = len;
      n_in = 0; exp_sat = 0;
      cfg_mode = 2'(mode); cfg_bias = IN_W'(bias);
      cfg_dq_scale = 8'(dq); cfg_rq_scale = 8'(rq); cfg_len = LEN_W'(len);
      start = 1; start_cyc = cyc;
      @(posedge clk); #1 start = 0;
   endtask

   // leaves in_valid high so back-to-back calls stream continuously
   task automatic send(input logic [LANES*IN_W-1:0] x);
      exp_t e;
      bit s;
      int t = 0;
      logic signed [IN_W-1:0] lv;
      bus.in_valid = 1; bus.in_data = x;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.nsat = 0;
            for (int i = 0; i < LANES; i++) begin
               lv = x[i*IN_W +: IN_W];
               e.data[i*OUT_W +: OUT_W] = model(longint'(lv), s);
               e.nsat += int'(s);
            end
            e.last = n_in == c_len - 1;
            n_in++;
            exp_q.push_back(e);
            break;
         end
         if (++t > 200) begin chk("in_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input int tmo);
      int t = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && t < tmo) begin @(posedge clk); #1; t++; end
      chk("done_seen", done_cnt != d0, 1);
      @(posedge clk); #1;
   endtask

   task automatic chk_idle(input string p);
      chk({p, "_in_ready"}, bus.in_ready, 0);
      chk({p, "_out_valid"}, bus.out_valid, 0);
      chk({p, "_out_last"}, bus.out_last, 0);
      chk({p, "_out_data"}, bus.out_data, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_done"}, done, 0);
      chk({p, "_sat_cnt"}, sat_cnt, 0);
   endtask

   task automatic one_beat(input int mode, input int rq, input int x, input logic [7:0] want, input string tag);
      out_log.delete();
      start_tile(mode, 0, 128, rq, 1);
      send(pk(x, x / 2, -x, 0));
      bus.in_valid = 0;
      wait_done(50);
      chk(tag, out_log[0], want);
   endtask

   initial begin
      int n0, d0, len;
      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
      repeat (3) @(posedge clk);
      #1 chk_idle("rst");
      rst = 0;
      @(posedge clk); #1;

      out_log.delete(); n0 = n_out;
      start_tile(3, 0, 128, 64, 2);
      send(pk(16384, 0, 1000, -1000));
      send(pk(-16384, 300000, -300000, 5));
      bus.in_valid = 0;
      wait_done(50);
      chk("hsw_beat0", out_log[0], 8'd43);
      chk("hsw_beat1", out_log[1], 8'hEB);
      chk("hsw_count", n_out - n0, 2);
      chk("hsw_done_lat", done_cyc - last_cyc, 1);
      chk("hsw_busy_idle", busy, 0);

      out_log.delete();
      start_tile(3, 0, 128, 64, 1);
      send(pk(65536, 0, -65536, 16384));
      bus.in_valid = 0;
      wait_done(50);
      chk("hsw_sat_out", out_log[0], 8'd127);
      chk("hsw_sat_cnt", sat_cnt, SAT_EN ? 16'd1 : 16'd0);

      one_beat(2, 16, 131072, 8'd96, "relu6_out");
      one_beat(1, 64, -16384, 8'd0, "relu_out");
      one_beat(0, 64, -16384, 8'hC0, "ident_out");

      n0 = n_out; saw_stall = 0;
      start_tile(0, 0, 128, 64, 8);
      fork
         begin
            for (int k = 0; k < 8; k++) send(pk(k * 5000 - 20000, k * 300, -k * 7000, 8192 + k));
            bus.in_valid = 0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1;
         end
      join
      wait_done(100);
      chk("bp_count", n_out - n0, 8);
      chk("bp_stall", saw_stall, 1);
      chk("bp_busy_idle", busy, 0);

      n0 = n_out; d0 = done_cnt;
      start_tile(1, 0, 128, 64, 0);
      wait_done(10);
      repeat (3) @(posedge clk);
      #1 chk("len0_lat", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
      chk("len0_pulses", done_cnt - d0, 1);
      chk("len0_no_out", n_out - n0, 0);

      rand_rdy = 1;
      for (int t = 0; t < 5; t++) begin
         n0 = n_out;
         len = $urandom_range(1, 6);
         start_tile($urandom_range(0, 3), int'($urandom_range(0, 8191)) - 4096,
                    $urandom_range(0, 255), $urandom_range(0, 255), len);
         for (int k = 0; k < len; k++) send(LANES * IN_W'({$urandom, $urandom, $urandom}));
         bus.in_valid = 0;
         wait_done(300);
         chk("rnd_count", n_out - n0, len);
         chk("rnd_sat_cnt", sat_cnt, SAT_EN ? 16'(exp_sat) : 16'd0);
      end
      rand_rdy = 0;
      @(posedge clk); #2 bus.out_ready = 1;
      @(posedge clk); #1;

      start_tile(0, 0, 128, 64, 8);
      for (int k = 0; k < 4; k++) send(pk(40000 * k, -3000, 7, 123456));
      rst = 1;
      @(posedge clk); #1;
      chk_idle("mid_rst");
      bus.in_valid = 0;
      exp_q.delete();
      @(posedge clk); #1 rst = 0;
      @(posedge clk); #1;

      out_log.delete();
      start_tile(1, 0, 128, 64, 1);
      send(pk(16384, -16384, 0, 0));
      bus.in_valid = 0;
      wait_done(50);
      chk("post_rst_out", out_log[0], 8'd64);
      chk("post_rst_q_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/act_requant_pipe.md
Name: act_requant_pipe

Overview:
Multi-lane streaming post-convolution activation and requantisation unit. Per lane: bias add and dequant scaling, then one of four activations (identity, ReLU, ReLU6, h_swish), then requant scaling with round-half-up and saturation to signed OUT_W. It sits between the DLA accumulator output and the output buffer. A tile-length FSM handles the valid/ready streaming, runtime config latched at start, out_last generation and a done pulse.

Parameters:
LANES, 4, parallel channels per beat
IN_W, 24, signed accumulator width per lane
OUT_W, 8, signed output width per lane
DQ_SHIFT, 13, right shift after dequant multiply (result Q.8, 1.0 = 256)
RQ_SHIFT, 8, right shift after requant multiply
LEN_W, 16, tile length counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; latches cfg_* and begins tile (honoured in IDLE only)
cfg_mode  in  2  0 identity, 1 ReLU, 2 ReLU6, 3 h_swish
cfg_bias  in  IN_W  signed bias, shared by all lanes
cfg_dq_scale  in  8  unsigned dequant multiplier
cfg_rq_scale  in  8  unsigned requant multiplier
cfg_len  in  LEN_W  beats in tile
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W]
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]
out_last  out  1  high with final beat of tile
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile completion
sat_cnt  out  16  saturation event count (optional feature)

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_last, busy, done, sat_cnt = 0; out_data = 0; all stage valids cleared; counters 0. Reset mid-tile drops in-flight data. No done pulse.
- FSM: IDLE -> RUN on start (cfg latched same edge). If cfg_len = 0, IDLE -> DONE instead. RUN: in_ready = stage1 can advance; input counter increments per accepted beat. When in_cnt reaches cfg_len: in_ready = 0 and go to DRAIN. DRAIN -> DONE on handshake of out_last beat. DONE: done = 1 for one cycle, then IDLE. start outside IDLE is ignored.
- Pipeline: 3 registered stages (S1 dequant, S2 activation, S3 requant/saturate). Latency 3 cycles, throughput 1 beat/cycle. Each stage holds while the next is full and not advancing. Stage k advances when stage k+1 is empty or advancing. out_valid = S3 valid. No beat lost or duplicated under any out_ready pattern.
- S1: d = ((x + bias) * dq_scale) >>> DQ_SHIFT. Signed, full precision (IN_W+9 bits min), arithmetic shift.
- S2, with Q.8 constants 768 = 3.0 and 1536 = 6.0:
  - mode0: y = d
  - mode1: y = max(d, 0)
  - mode2: y = min(max(d, 0), 1536)
  - mode3: y = 0 if d <= -768; d if d >= 768; else (d*(d+768)*43) >>> 16
- S3: r = (y*rq_scale + 2^(RQ_SHIFT-1)) >>> RQ_SHIFT, then clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- out_cnt increments on output handshake. out_last = out_valid & (out_cnt == cfg_len-1).
- Simultaneous start and in_valid in IDLE: the beat is not accepted that cycle (in_ready = 0 in IDLE).

Optional Feature:
ACT_SAT_CNT_EN: defined -> sat_cnt counts lanes clamped in S3 on output handshake. It saturates at 0xFFFF, clears on start and on rst. Undefined -> sat_cnt tied 0 and no counter logic.

Test Plan:
- Test config for all cases below: dq_scale = 128, bias = 0, rq_scale = 64 unless stated.
- mode3, len = 2, lane0 x = 16384 then -16384 -> out lane0 = 43 then -21. out_last on beat 2. done 1 cycle after that handshake.
- mode3, x = 65536 (d = 1024) -> y = 1024, r = 256 -> out 127. With ACT_SAT_CNT_EN, sat_cnt = 1 per saturated lane.
- mode2, rq_scale = 16, x = 131072 -> out 96. mode1, x = -16384 -> out 0. mode0, x = -16384 -> d = -256 -> out -64.
- len = 8, continuous input, out_ready low cycles 4-8 -> 8 outputs in order, no loss. in_ready deasserts once pipeline is full. busy high until done.
- start with len = 0 -> done pulse 2 cycles after start, no out_valid. rst asserted mid-tile -> all outputs 0 next cycle, state IDLE.
